mac_pipe_ctrl: RTL

- Sequencing controller for the single-precision FMA datapath, covering Booth partial-product generation, the Wallace tree, the final adder and normalise/round.
- Two requesters share one MAC pipeline: req0 is the integer/FP issue port and req1 is the accumulate-loopback port.
- The block arbitrates round-robin between them.
- It drives per-stage register load enables and the operand-select mux, carries tag/source sideband alongside the data, and applies output backpressure with flush.

---
 rtl/mac_pipe_ctrl_pkg.sv | 13 +
 rtl/mac_pipe_ctrl_rr_arb2.sv | 36 +++
 rtl/mac_pipe_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mac_pipe_ctrl_pkg.sv
// Shared constants and types for the MAC pipeline sequencing controller.
package mac_pkg;

    localparam int unsigned STAGES_DEF = 3;
    localparam int unsigned TAG_DEF    = 4;
    localparam int unsigned PERF_W     = 32;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_e;

endpackage

// File: rtl/mac_pipe_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an accepted transfer.
module rr_arb2
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output src_e       grant_idx,
    output src_e       last_grant
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_REQ1;
        end else if (advance && (valid != 2'b00)) begin
            last_grant <= grant_idx;
        end
    end

    always_comb begin
        grant_idx = SRC_REQ0;
        grant     = 2'b00;
        case (valid)
            2'b01:   grant_idx = SRC_REQ0;
            2'b10:   grant_idx = SRC_REQ1;
            2'b11:   grant_idx = (last_grant == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
            default: grant_idx = SRC_REQ0;
        endcase
        if (valid != 2'b00) begin
            grant = (grant_idx == SRC_REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mac_pipe_ctrl.sv
// Sequencing controller for the shared FMA pipeline: arbitration, stage enables, sideband, flush.
// Optional performance counters are built when MAC_PIPE_PERF_EN is defined.
module mac_pipe_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned PARM_STAGES = STAGES_DEF,
    parameter int unsigned PARM_TAG    = TAG_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req0_valid_i,
    input  logic [PARM_TAG-1:0]    req0_tag_i,
    output logic                   req0_ready_o,
    input  logic                   req1_valid_i,
    input  logic [PARM_TAG-1:0]    req1_tag_i,
    output logic                   req1_ready_o,
    input  logic                   flush_i,
    output logic                   sel_o,
    output logic [PARM_STAGES-1:0] stage_en_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [PARM_TAG-1:0]    rsp_tag_o,
    output logic                   rsp_src_o,
    output logic                   busy_o,
    output logic [PERF_W-1:0]      perf_ops_o,
    output logic [PERF_W-1:0]      perf_stall_o
);

    logic [PARM_STAGES-1:0] v;
    logic [PARM_STAGES-1:0] src_q;
    logic [PARM_TAG-1:0]    tag_q [PARM_STAGES];
    logic [PARM_STAGES-1:0] load;
    logic [1:0]             grant;
    src_e                   grant_idx;
    src_e                   last_grant;
    logic                   granted_once;
    logic                   accept;
    logic                   any_req;

    // load[k] is true when some slot at or after k is empty, or the result drains;
    // written as a reduction rather than a chain so the vector has no self-dependency.
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < PARM_STAGES; k++) begin
            load[k] = rsp_ready_i;
            for (int unsigned j = k; j < PARM_STAGES; j++) begin
                load[k] = load[k] | !v[j];
            end
        end
    end

    assign any_req = req0_valid_i | req1_valid_i;
    assign accept  = any_req & load[0] & !flush_i;

    rr_arb2 u_arb (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .valid      ({req1_valid_i, req0_valid_i}),
        .advance    (accept),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .last_grant (last_grant)
    );

    assign req0_ready_o = grant[0] & load[0] & !flush_i;
    assign req1_ready_o = grant[1] & load[1'b0] & !flush_i;
    assign stage_en_o   = flush_i ? '0 : load;

    // Idle select shows 0 until the first grant, then tracks the last-grant pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_once <= 1'b0;
        end else if (accept) begin
            granted_once <= 1'b1;
        end
    end

    always_comb begin
        sel_o = 1'b0;
        if (any_req) begin
            sel_o = grant_idx;
        end else if (granted_once) begin
            sel_o = last_grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v     <= '0;
            src_q <= '0;
            for (int unsigned k = 0; k < PARM_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else if (flush_i) begin
            v <= '0;
        end else begin
            if (load[0]) begin
                v[0]     <= accept;
                src_q[0] <= grant_idx;
                tag_q[0] <= (grant_idx == SRC_REQ1) ? req1_tag_i : req0_tag_i;
            end
            for (int unsigned k = 1; k < PARM_STAGES; k++) begin
                if (load[k]) begin
                    v[k]     <= v[k-1];
                    src_q[k] <= src_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    assign rsp_valid_o = v[PARM_STAGES-1];
    assign rsp_tag_o   = tag_q[PARM_STAGES-1];
    assign rsp_src_o   = src_q[PARM_STAGES-1];
    assign busy_o      = |v;

`ifdef MAC_PIPE_PERF_EN
    logic [PERF_W-1:0] ops_q;
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (rsp_valid_o && rsp_ready_i && (ops_q != '1)) begin
                ops_q <= ops_q + 1'b1;
            end
            if (rsp_valid_o && !rsp_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign perf_ops_o   = ops_q;
    assign perf_stall_o = stall_q;
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule
